// File: rtl/regfile_pkg.sv
// Shared types and constants for the register file unit: trap FSM states,
// status register bit positions and the sticky-bit mask.
package regfile_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        SAVE = 2'd1,
        TRAP = 2'd2,
        RET  = 2'd3
    } trap_state_t;

    localparam int STATUS_W = 20;

    localparam int ST_ZERO      = 0;
    localparam int ST_SIGN      = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_UNDERFLOW = 3;
    localparam int ST_CARRY     = 4;
    localparam int ST_DIV0      = 5;
    localparam int ST_HALF      = 6;
    localparam int ST_SAME_REG  = 7;
    localparam int ST_MEM_VIOL  = 8;
    localparam int ST_MEM_CORR  = 9;
    localparam int ST_TRAP_MODE = 10;
    localparam int ST_NESTED    = 11;
    localparam int ST_PENDING   = 12;

    localparam logic [STATUS_W-1:0] STICKY_MASK = 20'h00B20;

endpackage

// File: rtl/status_flags_reg.sv
// Status register: live ALU flags, sticky error bits with clear arbitration
// (a set in the same cycle as a clear wins), and trap state mirror bits.
module status_flags_reg
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flags_upd,
    input  logic [9:0]          flags_in,
    input  logic                clr_sticky,
    input  logic                nested_set,
    input  logic                trap_mode_d,
    input  logic                trap_pending_d,
    output logic [STATUS_W-1:0] status
);

    logic [STATUS_W-1:0] status_q;
    logic [STATUS_W-1:0] status_d;
    logic [STATUS_W-1:0] sticky_set;

    always_comb begin
        sticky_set              = '0;
        sticky_set[ST_DIV0]     = flags_upd & flags_in[ST_DIV0];
        sticky_set[ST_MEM_VIOL] = flags_upd & flags_in[ST_MEM_VIOL];
        sticky_set[ST_MEM_CORR] = flags_upd & flags_in[ST_MEM_CORR];
        sticky_set[ST_NESTED]   = nested_set;

        status_d = status_q;
        if (flags_upd) begin
            status_d[ST_CARRY:ST_ZERO] = flags_in[ST_CARRY:ST_ZERO];
            status_d[ST_HALF]          = flags_in[ST_HALF];
            status_d[ST_SAME_REG]      = flags_in[ST_SAME_REG];
        end
        if (clr_sticky) begin
            status_d = status_d & ~STICKY_MASK;
        end
        // OR-ing the sets after the clear gives set priority
        status_d = status_d | sticky_set;

        status_d[ST_TRAP_MODE]               = trap_mode_d;
        status_d[ST_PENDING]                 = trap_pending_d;
        status_d[STATUS_W-1:ST_PENDING+1]    = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    assign status = status_q;

endmodule

// File: rtl/register_file_unit.sv
// Register file unit: GPR array, auto-incrementing instruction pointer and a
// trap save/restore FSM. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module register_file_unit
    import regfile_pkg::*;
#(
    parameter int                DATA_W      = 20,
    parameter int                NUM_GPR     = 6,
    parameter int                INC_STEP    = 1,
    parameter logic [DATA_W-1:0] TRAP_VECTOR = 20'h00100
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [$clog2(NUM_GPR)-1:0] wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [$clog2(NUM_GPR)-1:0] rd_addr_a,
    input  logic [$clog2(NUM_GPR)-1:0] rd_addr_b,
    output logic [DATA_W-1:0]          rd_data_a,
    output logic [DATA_W-1:0]          rd_data_b,
    input  logic                       ip_inc,
    input  logic                       ip_load,
    input  logic [DATA_W-1:0]          ip_load_val,
    output logic [DATA_W-1:0]          ip,
    input  logic                       flags_upd,
    input  logic [9:0]                 flags_in,
    input  logic                       clr_sticky,
    input  logic                       trap_req,
    input  logic                       trap_ret,
    output logic [DATA_W-1:0]          status,
    output logic                       trap_mode
);

    localparam logic [DATA_W-1:0] STEP = DATA_W'(INC_STEP);

    logic [DATA_W-1:0] gpr_q [NUM_GPR];
    logic              wr_ok;

    assign wr_ok = wr_en && (32'(wr_addr) < 32'(NUM_GPR));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr_q[i] <= '0;
            end
        end else if (wr_ok) begin
            gpr_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_a = (32'(rd_addr_a) < 32'(NUM_GPR)) ? gpr_q[rd_addr_a] : '0;
        rd_data_b = (32'(rd_addr_b) < 32'(NUM_GPR)) ? gpr_q[rd_addr_b] : '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
        if (wr_ok && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
`endif
    end

    trap_state_t       state_q, state_d;
    logic [DATA_W-1:0] ip_q, ip_d;
    logic [DATA_W-1:0] saved_ip_q, saved_ip_d;
    logic              nested_set;
    logic              trap_mode_d;
    logic              trap_pending_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            ip_q       <= '0;
            saved_ip_q <= '0;
        end else begin
            state_q    <= state_d;
            ip_q       <= ip_d;
            saved_ip_q <= saved_ip_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (trap_req) state_d = SAVE;
            SAVE:    state_d = TRAP;
            TRAP:    if (trap_ret) state_d = RET;
            default: state_d = RUN;
        endcase
    end

    // SAVE and RET own the ip; external load/increment are dropped there
    always_comb begin
        ip_d       = ip_q;
        saved_ip_d = saved_ip_q;
        case (state_q)
            SAVE: begin
                saved_ip_d = ip_q + STEP;
                ip_d       = TRAP_VECTOR;
            end
            RET: ip_d = saved_ip_q;
            default: begin
                if (ip_load)     ip_d = ip_load_val;
                else if (ip_inc) ip_d = ip_q + STEP;
            end
        endcase
        nested_set     = (state_q == TRAP) && trap_req;
        trap_mode_d    = (state_d == TRAP);
        trap_pending_d = (state_d == SAVE);
    end

    logic [STATUS_W-1:0] status_w;

    status_flags_reg u_status (
        .clk            (clk),
        .rst_n          (rst_n),
        .flags_upd      (flags_upd),
        .flags_in       (flags_in),
        .clr_sticky     (clr_sticky),
        .nested_set     (nested_set),
        .trap_mode_d    (trap_mode_d),
        .trap_pending_d (trap_pending_d),
        .status         (status_w)
    );

    assign ip        = ip_q;
    assign status    = DATA_W'(status_w);
    assign trap_mode = (state_q == TRAP);

endmodule
